count_seq_ctrl: RTL and testbench

COUNT_SEQ_CTRL -- requirements
Module: count_seq_ctrl

---
 rtl/count_seq_ctrl_pkg.sv | 25 ++
 rtl/count_seq_ctrl_up_counter_core.sv | 43 ++++
 rtl/count_seq_ctrl.sv | 131 +++++++++++++
 tb/tb_count_seq_ctrl.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/count_seq_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : count_seq_ctrl_pkg
// Description : Shared state encodings, default widths and mode constants
//               for the count sequence controller.
// Revision    : 1.0
// ============================================================================
package count_seq_ctrl_pkg;

  // Controller states; the encoding is visible on state_out
  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    PAUSE = 2'b10,
    DONE  = 2'b11
  } state_t;

  localparam int DEFAULT_N  = 3;
  localparam int DEFAULT_PW = 8;

  localparam logic ONE_SHOT = 1'b0;
  localparam logic PERIODIC = 1'b1;

endpackage
`default_nettype wire

// File: rtl/count_seq_ctrl_up_counter_core.sv
`default_nettype none
// ============================================================================
// Module      : up_counter_core
// Description : W-bit up counter with synchronous clear and count enable.
//               Clear has priority over enable.
// Revision    : 1.0
// ============================================================================
module up_counter_core #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] count
);

  logic [W-1:0] count_d;
  logic [W-1:0] count_q;

  // Next count: clear wins, otherwise step by one when enabled
  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (en) begin
      count_d = count_q + W'(1);
    end
  end

  // Count register
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule
`default_nettype wire

// File: rtl/count_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : count_seq_ctrl
// Description : Launches a 0..tc count sequence in one-shot or periodic mode,
//               with pause, abort, a one-cycle done pulse and a count of
//               completed periods.
// Revision    : 1.0
// ============================================================================
module count_seq_ctrl
  import count_seq_ctrl_pkg::*;
#(
  parameter int N  = DEFAULT_N,
  parameter int PW = DEFAULT_PW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          pause,
  input  logic          abort,
  input  logic          mode,
  input  logic [N-1:0]  term_cnt,
  output logic [N-1:0]  count_out,
  output logic          busy,
  output logic          done,
  output logic [PW-1:0] period_cnt,
  output logic [1:0]    state_out
);

  state_t        state_q,  state_d;
  logic [N-1:0]  tc_q,     tc_d;
  logic          mode_q,   mode_d;
  logic          done_q,   done_d;
  logic [PW-1:0] period_q, period_d;

  logic          cnt_clr;
  logic          cnt_en;
  logic [N-1:0]  cnt_val;
  logic          at_term;

  up_counter_core #(
    .W (N)
  ) u_counter (
    .clk   (clk),
    .rst   (rst),
    .clr   (cnt_clr),
    .en    (cnt_en),
    .count (cnt_val)
  );

  assign at_term = (cnt_val == tc_q);

  // Next-state, latch and counter control; abort outranks pause, which
  // outranks the terminal-count / increment decision
  always_comb begin
    state_d  = state_q;
    tc_d     = tc_q;
    mode_d   = mode_q;
    done_d   = 1'b0;
    period_d = period_q;
    cnt_clr  = 1'b0;
    cnt_en   = 1'b0;

    if (abort) begin
      state_d  = IDLE;
      period_d = '0;
      cnt_clr  = 1'b1;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            state_d  = RUN;
            tc_d     = term_cnt;
            mode_d   = mode;
            period_d = '0;
            cnt_clr  = 1'b1;
          end
        end
        RUN: begin
          if (pause) begin
            state_d = PAUSE;
          end else if (at_term) begin
            done_d = 1'b1;
            if (mode_q == PERIODIC) begin
              cnt_clr  = 1'b1;
              period_d = period_q + PW'(1);
            end else begin
              state_d = DONE;
            end
          end else begin
            cnt_en = 1'b1;
          end
        end
        PAUSE: begin
          // The edge that leaves PAUSE does not count; counting resumes
          // on the edge after
          if (!pause) begin
            state_d = RUN;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // Controller registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      tc_q     <= '0;
      mode_q   <= ONE_SHOT;
      done_q   <= 1'b0;
      period_q <= '0;
    end else begin
      state_q  <= state_d;
      tc_q     <= tc_d;
      mode_q   <= mode_d;
      done_q   <= done_d;
      period_q <= period_d;
    end
  end

  assign count_out  = cnt_val;
  assign busy       = (state_q == RUN) || (state_q == PAUSE);
  assign done       = done_q;
  assign period_cnt = period_q;
  assign state_out  = state_q;

endmodule
`default_nettype wire

// File: tb/tb_count_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_count_seq_ctrl
// Description : Self-checking bench for count_seq_ctrl: a vector table, a
//               few directed sequences and random stimulus against a
//               behavioural model. A second instance with PW=2 shares the
//               inputs to exercise period counter wrap.
// Revision    : 1.0
// ============================================================================
module tb_count_seq_ctrl;

  localparam int N = 3;

  logic         clk = 1'b0;
  logic         rst, start, pause, abort, mode;
  logic [N-1:0] term_cnt;

  logic [N-1:0] count_out, count_out2;
  logic         busy, busy2, done, done2;
  logic [7:0]   period_cnt;
  logic [1:0]   period_cnt2;
  logic [1:0]   state_out, state_out2;

  int total = 0;
  int bad   = 0;

  count_seq_ctrl #(.N(N), .PW(8)) dut (
    .clk(clk), .rst(rst), .start(start), .pause(pause), .abort(abort),
    .mode(mode), .term_cnt(term_cnt), .count_out(count_out), .busy(busy),
    .done(done), .period_cnt(period_cnt), .state_out(state_out)
  );

  count_seq_ctrl #(.N(N), .PW(2)) dut_pw2 (
    .clk(clk), .rst(rst), .start(start), .pause(pause), .abort(abort),
    .mode(mode), .term_cnt(term_cnt), .count_out(count_out2), .busy(busy2),
    .done(done2), .period_cnt(period_cnt2), .state_out(state_out2)
  );

  always #5 clk = ~clk;

  // Reference model: activity flags plus plain integer counters
  bit m_running, m_paused, m_finished, m_done, m_periodic;
  int m_cnt, m_tc, m_period;

  function automatic int m_state();
    if (m_paused)   return 2;
    if (m_running)  return 1;
    if (m_finished) return 3;
    return 0;
  endfunction

  task automatic model_step();
    m_done = 1'b0;
    if (rst) begin
      m_running = 0; m_paused = 0; m_finished = 0;
      m_cnt = 0; m_period = 0; m_tc = 0; m_periodic = 0;
    end else if (abort) begin
      m_running = 0; m_paused = 0; m_finished = 0;
      m_cnt = 0; m_period = 0;
    end else if (m_running) begin
      if (pause) begin
        m_running = 0; m_paused = 1;
      end else if (m_cnt == m_tc) begin
        m_done = 1;
        if (m_periodic) begin
          m_cnt = 0; m_period = m_period + 1;
        end else begin
          m_running = 0; m_finished = 1;
        end
      end else begin
        m_cnt = m_cnt + 1;
      end
    end else if (m_paused) begin
      if (!pause) begin
        m_paused = 0; m_running = 1;
      end
    end else if (start) begin
      m_tc = int'(term_cnt); m_periodic = mode;
      m_cnt = 0; m_period = 0;
      m_running = 1; m_finished = 0;
    end
  endtask

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_model();
    chk("m_count",   int'(count_out),   m_cnt);
    chk("m_done",    int'(done),        int'(m_done));
    chk("m_state",   int'(state_out),   m_state());
    chk("m_busy",    int'(busy),        int'(m_running || m_paused));
    chk("m_period",  int'(period_cnt),  m_period % 256);
    chk("m_period2", int'(period_cnt2), m_period % 4);
    chk("m_count2",  int'(count_out2),  m_cnt);
    chk("m_done2",   int'(done2),       int'(m_done));
  endtask

  // One clock edge: advance the model, then sample the DUT 1 time unit later
  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check_model();
  endtask

  task automatic launch(input logic md, input int tc);
    start = 1'b1; mode = md; term_cnt = N'(tc);
    tick();
    start = 1'b0;
  endtask

  typedef struct packed {
    logic         rst, start, pause, abort, mode;
    logic [N-1:0] tc;
    logic [N-1:0] e_cnt;
    logic         e_done;
    logic [1:0]   e_state;
    logic [7:0]   e_period;
  } vec_t;

  vec_t tbl [10];

  initial begin
    int e;
    int dones;

    // One-shot, tc=5: 0..5 then DONE with one done pulse, count holds 5
    tbl[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 3'd0, 1'b0, 2'd0, 8'd0};
    tbl[1] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd5, 3'd0, 1'b0, 2'd1, 8'd0};
    tbl[2] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd1, 3'd1, 1'b0, 2'd1, 8'd0};
    tbl[3] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 3'd2, 1'b0, 2'd1, 8'd0};
    tbl[4] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd2, 3'd3, 1'b0, 2'd1, 8'd0};
    tbl[5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 3'd4, 1'b0, 2'd1, 8'd0};
    tbl[6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 3'd5, 1'b0, 2'd1, 8'd0};
    tbl[7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 3'd5, 1'b1, 2'd3, 8'd0};
    tbl[8] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 3'd5, 1'b0, 2'd3, 8'd0};
    tbl[9] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 3'd5, 1'b0, 2'd3, 8'd0};

    rst = 1'b1; start = 1'b0; pause = 1'b0; abort = 1'b0; mode = 1'b0;
    term_cnt = '0;
    m_running = 0; m_paused = 0; m_finished = 0; m_done = 0; m_periodic = 0;
    m_cnt = 0; m_tc = 0; m_period = 0;

    for (int i = 0; i < 10; i++) begin
      rst = tbl[i].rst; start = tbl[i].start; pause = tbl[i].pause;
      abort = tbl[i].abort; mode = tbl[i].mode; term_cnt = tbl[i].tc;
      tick();
      chk($sformatf("tbl%0d_count", i),  int'(count_out),  int'(tbl[i].e_cnt));
      chk($sformatf("tbl%0d_done", i),   int'(done),       int'(tbl[i].e_done));
      chk($sformatf("tbl%0d_state", i),  int'(state_out),  int'(tbl[i].e_state));
      chk($sformatf("tbl%0d_period", i), int'(period_cnt), int'(tbl[i].e_period));
    end
    start = 1'b0; pause = 1'b0;

    // Periodic tc=3 for 20 edges: done every 4th edge, 5 periods
    rst = 1'b1; tick(); rst = 1'b0;
    launch(1'b1, 3);
    dones = 0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (done) begin
        dones++;
        chk("per_done_spacing", i % 4, 0);
      end
    end
    chk("per_dones", dones, 5);
    chk("per_period5", int'(period_cnt), 5);

    // One-shot tc=6: pause over three edges at count 2, plus the resume edge,
    // freezes the count for four extra cycles; term_cnt change is ignored
    rst = 1'b1; tick(); rst = 1'b0;
    launch(1'b0, 6);
    e = 0;
    tick(); tick(); e = 2;
    chk("pause_pre_count", int'(count_out), 2);
    pause = 1'b1; term_cnt = 3'd1;
    for (int i = 0; i < 3; i++) begin
      tick(); e++;
      chk("pause_hold_count", int'(count_out), 2);
      chk("pause_state", int'(state_out), 2);
    end
    pause = 1'b0;
    tick(); e++;
    chk("resume_count", int'(count_out), 2);
    chk("resume_state", int'(state_out), 1);
    while (!done && e < 40) begin
      tick(); e++;
    end
    chk("pause_done_latency", e, 11);
    chk("pause_done_count", int'(count_out), 6);

    // Pause coinciding with terminal count defers done
    rst = 1'b1; tick(); rst = 1'b0;
    launch(1'b0, 1);
    tick();
    pause = 1'b1; tick();
    chk("coincide_no_done", int'(done), 0);
    pause = 1'b0; tick(); tick();
    chk("coincide_late_done", int'(done), 1);

    // Periodic abort at count 4 after one full period
    rst = 1'b1; tick(); rst = 1'b0;
    launch(1'b1, 5);
    for (int i = 0; i < 10; i++) tick();
    chk("abort_pre_count", int'(count_out), 4);
    chk("abort_pre_period", int'(period_cnt), 1);
    abort = 1'b1; tick(); abort = 1'b0;
    chk("abort_state", int'(state_out), 0);
    chk("abort_count", int'(count_out), 0);
    chk("abort_period", int'(period_cnt), 0);
    chk("abort_done", int'(done), 0);

    // Reset mid-RUN
    launch(1'b1, 5);
    for (int i = 0; i < 9; i++) tick();
    rst = 1'b1; tick(); rst = 1'b0;
    chk("rst_state", int'(state_out), 0);
    chk("rst_count", int'(count_out), 0);
    chk("rst_period", int'(period_cnt), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_busy", int'(busy), 0);

    // tc=0 periodic: done every cycle; PW=2 copy wraps 5 -> 1
    launch(1'b1, 0);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("tc0_done", int'(done), 1);
    end
    chk("tc0_period8", int'(period_cnt), 5);
    chk("tc0_period2_wrap", int'(period_cnt2), 1);

    // start held through DONE relaunches with tc=7; count reaches 7 cleanly
    rst = 1'b1; tick(); rst = 1'b0;
    start = 1'b1; mode = 1'b0; term_cnt = 3'd2;
    tick();
    term_cnt = 3'd7;
    tick(); tick(); tick();
    chk("hold_done", int'(done), 1);
    chk("hold_done_state", int'(state_out), 3);
    tick();
    chk("relaunch_state", int'(state_out), 1);
    chk("relaunch_count", int'(count_out), 0);
    start = 1'b0;
    for (int i = 0; i < 7; i++) tick();
    chk("max_count", int'(count_out), 7);
    tick();
    chk("max_done", int'(done), 1);
    chk("max_done_count", int'(count_out), 7);

    // Random stimulus against the model
    for (int i = 0; i < 3000; i++) begin
      rst      = ($urandom_range(0, 99) == 0);
      abort    = ($urandom_range(0, 49) == 0);
      start    = ($urandom_range(0, 5) == 0);
      pause    = ($urandom_range(0, 3) == 0);
      mode     = 1'($urandom_range(0, 1));
      term_cnt = N'($urandom_range(0, 7));
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
